// File: rtl/hydration_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hydration_pkg
//  Description : Shared types and constants for the hydration reminder
//                scheduler and its target decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package hydration_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ALERT  = 2'd1,
      SNOOZE = 2'd2
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam int HOURS_PER_DAY = 24;

   // A BCD digit is legal only in the range 0..9
   function automatic logic bcd_ok(input bcd_t d);
      return (d <= 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hydration_target.sv
`default_nettype none
// ============================================================================
//  Module      : hydration_target
//  Description : Decodes the BCD time of day into an hour and produces the
//                saturating hydration target level for that hour. Any
//                malformed time yields a zero target.
//  Revision    : 1.0  initial release
// ============================================================================
module hydration_target
   import hydration_pkg::*;
#(
   parameter int WAKE_HOUR = 8,
   parameter int MAX_LEVEL = 15
) (
   input  logic [3:0] i_h_msd,
   input  logic [3:0] i_h_lsd,
   input  logic [3:0] i_m_msd,
   input  logic [3:0] i_m_lsd,
   input  logic [3:0] i_s_msd,
   input  logic [3:0] i_s_lsd,
   output logic [3:0] o_target
);

   localparam logic [4:0] C_WAKE  = 5'(WAKE_HOUR);
   localparam logic [4:0] C_MAX   = 5'(MAX_LEVEL);
   localparam logic [7:0] C_HOURS = 8'(HOURS_PER_DAY);

   logic [7:0] w_hour;
   logic       w_valid;
   logic [4:0] w_span;
   logic [4:0] w_target;

   // Hour is formed at 8 bits so an out-of-range tens digit cannot alias
   assign w_hour  = ({4'd0, i_h_msd} * 8'd10) + {4'd0, i_h_lsd};

   assign w_valid = bcd_ok(i_h_msd) && bcd_ok(i_h_lsd) &&
                    bcd_ok(i_m_msd) && bcd_ok(i_m_lsd) &&
                    bcd_ok(i_s_msd) && bcd_ok(i_s_lsd) &&
                    (i_h_msd <= 4'd2) && (w_hour < C_HOURS);

   // Target grows by one level per waking hour, clipped at the top of scale
   always_comb begin
      w_span   = w_hour[4:0] - C_WAKE + 5'd1;
      w_target = 5'd0;
      if (w_valid && (w_hour[4:0] >= C_WAKE)) begin
         w_target = (w_span > C_MAX) ? C_MAX : w_span;
      end
   end

   assign o_target = w_target[3:0];

endmodule
`default_nettype wire

// File: rtl/hydration_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : hydration_scheduler
//  Description : Per-second hydration check. Raises a blinking reminder on a
//                water deficit, handles acknowledge/snooze and keeps a
//                saturating per-day count of missed reminders.
//  Revision    : 1.0  initial release
// ============================================================================
module hydration_scheduler
   import hydration_pkg::*;
#(
   parameter int WAKE_HOUR     = 8,
   parameter int MAX_LEVEL     = 15,
   parameter int SNOOZE_TICKS  = 300,
   parameter int ALERT_TIMEOUT = 60
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       tick,
   input  logic [3:0] hMSD,
   input  logic [3:0] hLSD,
   input  logic [3:0] mMSD,
   input  logic [3:0] mLSD,
   input  logic [3:0] sMSD,
   input  logic [3:0] sLSD,
   input  logic [3:0] waterLevel,
   input  logic       ack,
   output logic       remind,
   output logic       blink,
   output logic       snoozeActive,
   output logic [3:0] missedCount
);

   localparam logic [15:0] C_SNOOZE_LOAD = 16'(SNOOZE_TICKS);
   localparam logic [15:0] C_ALERT_LAST  = 16'(ALERT_TIMEOUT - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_alert_cnt;
   logic [15:0] w_alert_cnt_nxt;
   logic [15:0] r_snooze_cnt;
   logic [15:0] w_snooze_cnt_nxt;
   logic        r_blink;
   logic        w_blink_nxt;
   logic [3:0]  r_missed;
   logic [3:0]  w_missed_nxt;
   logic        r_ack_prev;
   logic        r_remind;
   logic        r_snooze_act;

   logic [3:0]  w_target;
   logic        w_deficit;
   logic        w_ack_rise;
   logic        w_rollover;

   hydration_target #(
      .WAKE_HOUR (WAKE_HOUR),
      .MAX_LEVEL (MAX_LEVEL)
   ) u_target (
      .i_h_msd  (hMSD),
      .i_h_lsd  (hLSD),
      .i_m_msd  (mMSD),
      .i_m_lsd  (mLSD),
      .i_s_msd  (sMSD),
      .i_s_lsd  (sLSD),
      .o_target (w_target)
   );

   assign w_deficit  = (w_target > waterLevel);
   assign w_ack_rise = ack & ~r_ack_prev;
   assign w_rollover = tick && (hMSD == 4'd0) && (hLSD == 4'd0) &&
                       (mMSD == 4'd0) && (mLSD == 4'd0) &&
                       (sMSD == 4'd0) && (sLSD == 4'd0);

   // Next-state and counter update; midnight overrides everything, then
   // deficit clear, acknowledge, timeout and plain counting in that order
   always_comb begin
      w_state_nxt      = r_state;
      w_alert_cnt_nxt  = r_alert_cnt;
      w_snooze_cnt_nxt = r_snooze_cnt;
      w_blink_nxt      = r_blink;
      w_missed_nxt     = r_missed;

      if (w_rollover) begin
         w_state_nxt  = IDLE;
         w_blink_nxt  = 1'b0;
         w_missed_nxt = 4'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (tick && w_deficit) begin
                  w_state_nxt     = ALERT;
                  w_alert_cnt_nxt = 16'd0;
                  w_blink_nxt     = 1'b1;
               end
            end
            ALERT: begin
               if (tick && !w_deficit) begin
                  w_state_nxt = IDLE;
                  w_blink_nxt = 1'b0;
               end else if (w_ack_rise) begin
                  w_state_nxt      = SNOOZE;
                  w_snooze_cnt_nxt = C_SNOOZE_LOAD;
                  w_blink_nxt      = 1'b0;
               end else if (tick && (r_alert_cnt == C_ALERT_LAST)) begin
                  w_state_nxt      = SNOOZE;
                  w_snooze_cnt_nxt = C_SNOOZE_LOAD;
                  w_blink_nxt      = 1'b0;
                  w_missed_nxt     = (r_missed == 4'hF) ? r_missed : r_missed + 4'd1;
               end else if (tick) begin
                  w_alert_cnt_nxt = r_alert_cnt + 16'd1;
                  w_blink_nxt     = ~r_blink;
               end
            end
            SNOOZE: begin
               if (tick && (!w_deficit || (r_snooze_cnt == 16'd1))) begin
                  w_state_nxt = IDLE;
               end else if (tick) begin
                  w_snooze_cnt_nxt = r_snooze_cnt - 16'd1;
               end
            end
            default: begin
               w_state_nxt = IDLE;
               w_blink_nxt = 1'b0;
            end
         endcase
      end
   end

   // State, counters and registered outputs
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         r_state      <= IDLE;
         r_alert_cnt  <= 16'd0;
         r_snooze_cnt <= 16'd0;
         r_blink      <= 1'b0;
         r_missed     <= 4'd0;
         r_ack_prev   <= 1'b0;
         r_remind     <= 1'b0;
         r_snooze_act <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_alert_cnt  <= w_alert_cnt_nxt;
         r_snooze_cnt <= w_snooze_cnt_nxt;
         r_blink      <= w_blink_nxt;
         r_missed     <= w_missed_nxt;
         r_ack_prev   <= ack;
         r_remind     <= (w_state_nxt == ALERT);
         r_snooze_act <= (w_state_nxt == SNOOZE);
      end
   end

   assign remind       = r_remind;
   assign blink        = r_blink;
   assign snoozeActive = r_snooze_act;
   assign missedCount  = r_missed;

endmodule
`default_nettype wire

// File: tb/tb_hydration_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hydration_scheduler
//  Description : Self-checking bench for hydration_scheduler. A behavioural
//                model predicts the registered outputs for every cycle; the
//                prediction is queued at drive time and compared after the
//                following clock edge.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hydration_scheduler;

   localparam int WAKE_HOUR     = 8;
   localparam int MAX_LEVEL     = 15;
   localparam int SNOOZE_TICKS  = 3;
   localparam int ALERT_TIMEOUT = 4;

   localparam int M_IDLE   = 0;
   localparam int M_ALERT  = 1;
   localparam int M_SNOOZE = 2;

   logic       clk = 1'b0;
   logic       resetN = 1'b0;
   logic       tick = 1'b0;
   logic [3:0] hMSD = 4'd0, hLSD = 4'd0, mMSD = 4'd0, mLSD = 4'd0, sMSD = 4'd0, sLSD = 4'd0;
   logic [3:0] waterLevel = 4'd0;
   logic       ack = 1'b0;
   logic       remind, blink, snoozeActive;
   logic [3:0] missedCount;

   int n_checks = 0;
   int n_errors = 0;

   logic [6:0] q_exp[$];

   // Model state
   int m_state;
   int m_acnt;
   int m_scnt;
   bit m_blink;
   int m_missed;
   bit m_ackprev;

   hydration_scheduler #(
      .WAKE_HOUR     (WAKE_HOUR),
      .MAX_LEVEL     (MAX_LEVEL),
      .SNOOZE_TICKS  (SNOOZE_TICKS),
      .ALERT_TIMEOUT (ALERT_TIMEOUT)
   ) dut (
      .clk          (clk),
      .resetN       (resetN),
      .tick         (tick),
      .hMSD         (hMSD),
      .hLSD         (hLSD),
      .mMSD         (mMSD),
      .mLSD         (mLSD),
      .sMSD         (sMSD),
      .sLSD         (sLSD),
      .waterLevel   (waterLevel),
      .ack          (ack),
      .remind       (remind),
      .blink        (blink),
      .snoozeActive (snoozeActive),
      .missedCount  (missedCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int f_target(input int h1, input int h0, input int m1,
                                   input int m0, input int s1, input int s0);
      int hour;
      if (h1 > 9 || h0 > 9 || m1 > 9 || m0 > 9 || s1 > 9 || s0 > 9 || h1 > 2) return 0;
      hour = h1 * 10 + h0;
      if (hour > 23 || hour < WAKE_HOUR) return 0;
      return (hour - WAKE_HOUR + 1 > MAX_LEVEL) ? MAX_LEVEL : hour - WAKE_HOUR + 1;
   endfunction

   task automatic m_reset();
      m_state   = M_IDLE;
      m_acnt    = 0;
      m_scnt    = 0;
      m_blink   = 1'b0;
      m_missed  = 0;
      m_ackprev = 1'b0;
   endtask

   // Advance the model by one clock using the inputs currently driven
   task automatic m_eval();
      bit def, rise, midnight;
      def  = f_target(hMSD, hLSD, mMSD, mLSD, sMSD, sLSD) > int'(waterLevel);
      rise = ack && !m_ackprev;
      midnight = tick && {hMSD, hLSD, mMSD, mLSD, sMSD, sLSD} == 24'd0;
      if (midnight) begin
         m_state  = M_IDLE;
         m_missed = 0;
      end else if (m_state == M_IDLE) begin
         if (tick && def) begin
            m_state = M_ALERT;
            m_acnt  = 0;
            m_blink = 1'b1;
         end
      end else if (m_state == M_ALERT) begin
         if (tick && !def) begin
            m_state = M_IDLE;
         end else if (rise) begin
            m_state = M_SNOOZE;
            m_scnt  = SNOOZE_TICKS;
         end else if (tick && m_acnt == ALERT_TIMEOUT - 1) begin
            m_state = M_SNOOZE;
            m_scnt  = SNOOZE_TICKS;
            if (m_missed < 15) m_missed++;
         end else if (tick) begin
            m_acnt++;
            m_blink = !m_blink;
         end
      end else begin
         if (tick) begin
            if (!def || m_scnt == 1) m_state = M_IDLE;
            else m_scnt--;
         end
      end
      m_ackprev = ack;
   endtask

   function automatic logic [6:0] m_out();
      return {m_state == M_ALERT, (m_state == M_ALERT) && m_blink,
              m_state == M_SNOOZE, 4'(m_missed)};
   endfunction

   task automatic step(input logic t, input logic a, input string tag);
      logic [6:0] exp;
      @(negedge clk);
      tick = t;
      ack  = a;
      m_eval();
      q_exp.push_back(m_out());
      @(posedge clk);
      #1;
      exp = q_exp.pop_front();
      check(tag, {25'd0, remind, blink, snoozeActive, missedCount}, {25'd0, exp});
      tick = 1'b0;
   endtask

   task automatic set_time(input int h1, input int h0, input int m1,
                           input int m0, input int s1, input int s0);
      hMSD = 4'(h1); hLSD = 4'(h0); mMSD = 4'(m1);
      mLSD = 4'(m0); sMSD = 4'(s1); sLSD = 4'(s0);
   endtask

   initial begin
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_remind", remind, 0);
      check("rst_blink", blink, 0);
      check("rst_snooze", snoozeActive, 0);
      check("rst_missed", missedCount, 0);
      @(negedge clk);
      resetN = 1'b1;

      // Enter ALERT at 10:00:00 (target 3) and watch blink toggle
      set_time(1, 0, 0, 0, 0, 0);
      waterLevel = 4'd1;
      step(0, 0, "idle_no_tick");
      step(1, 0, "enter_alert");
      step(1, 0, "blink0");
      step(0, 0, "between_ticks");
      step(1, 0, "blink1");
      step(1, 0, "blink0b");

      // Acknowledge between ticks, hold ack, then snooze expires
      step(0, 1, "ack_to_snooze");
      step(0, 1, "ack_held");
      step(1, 1, "snooze_tick1");
      step(0, 0, "ack_release");
      step(1, 0, "snooze_tick2");
      step(1, 0, "snooze_tick3_idle");
      step(1, 0, "reenter_alert");

      // Timeout without ack, then ack coincident with the timeout tick
      for (int i = 0; i < ALERT_TIMEOUT; i++) step(1, 0, "timeout_run");
      check("missed_one", missedCount, 1);
      for (int i = 0; i < SNOOZE_TICKS; i++) step(1, 0, "snooze_drain");
      step(1, 0, "alert_again");
      for (int i = 0; i < ALERT_TIMEOUT - 1; i++) step(1, 0, "pre_timeout");
      step(1, 1, "ack_on_timeout");
      check("ack_wins_missed", missedCount, 1);
      step(0, 0, "ack_drop");
      for (int i = 0; i < SNOOZE_TICKS; i++) step(1, 0, "snooze_drain2");
      step(1, 0, "alert_sat");

      // Saturate the missed counter
      for (int k = 0; k < 16; k++) begin
         for (int i = 0; i < ALERT_TIMEOUT; i++) step(1, 0, "sat_timeout");
         for (int i = 0; i < SNOOZE_TICKS; i++) step(1, 0, "sat_snooze");
         step(1, 0, "sat_alert");
      end
      check("missed_saturated", missedCount, 15);

      // Deficit cleared while alerting
      waterLevel = 4'd3;
      step(1, 0, "deficit_clear");
      check("clear_remind", remind, 0);

      // Deficit clear coincident with ack rise goes to IDLE
      waterLevel = 4'd1;
      step(1, 0, "alert_for_clear_ack");
      waterLevel = 4'd3;
      step(1, 1, "clear_and_ack");
      step(0, 0, "ack_drop2");

      // Before wake hour target is zero; wake hour itself alerts on level 0
      waterLevel = 4'd0;
      set_time(0, 7, 5, 9, 5, 9);
      step(1, 0, "pre_wake");
      set_time(0, 8, 0, 0, 0, 0);
      step(1, 0, "wake_hour_alert");

      // Midnight clears missed count and forces IDLE out of ALERT
      set_time(0, 0, 0, 0, 0, 0);
      step(1, 0, "rollover");
      check("rollover_missed", missedCount, 0);

      // Invalid BCD hour digit yields no alert
      set_time(1, 10, 0, 0, 0, 1);
      step(1, 0, "bad_bcd");
      set_time(2, 4, 0, 0, 0, 1);
      step(1, 0, "hour_24");

      // Randomised mix of time, level, ack and tick
      for (int i = 0; i < 300; i++) begin
         if (i % 20 == 0)
            set_time($urandom_range(2, 0), $urandom_range(9, 0), $urandom_range(5, 0),
                     $urandom_range(9, 0), $urandom_range(5, 0), $urandom_range(9, 1));
         waterLevel = 4'($urandom_range(15, 0));
         step(1'($urandom_range(1, 0)), 1'($urandom_range(3, 0) == 0), "random");
      end

      // Asynchronous reset mid-SNOOZE
      set_time(1, 0, 0, 0, 0, 0);
      waterLevel = 4'd1;
      step(0, 0, "pre_async");
      step(1, 0, "async_alert");
      step(1, 0, "async_alert_tick");
      step(0, 1, "async_snooze");
      check("in_snooze", snoozeActive, 1);
      #2;
      resetN = 1'b0;
      #1;
      check("async_remind", remind, 0);
      check("async_blink", blink, 0);
      check("async_snooze_out", snoozeActive, 0);
      check("async_missed", missedCount, 0);
      m_reset();
      @(negedge clk);
      resetN = 1'b1;
      step(0, 0, "post_reset");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
